moving_avg_multi: RTL and testbench
===================================

Name: moving_avg_multi

Overview:
Parametrised successor to the single-channel moving average. It filters CHANNELS independent unsigned sample streams, such as x and y centroid coordinates from center_of_mass. It sits between the centroid/tracking stage and the overlay logic. Two filter types are selectable at run time: a power-of-two boxcar window, or an exponential moving average (EMA) with alpha = 2^-EMA_SHIFT. It also provides a primed flag, a synchronous flush, and registered outputs.

Parameters:
WIDTH, 11, bits per channel sample (unsigned)
CHANNELS, 2, number of independent channels packed in value_in/value_out
LOG2_DEPTH, 2, boxcar window depth = 2^LOG2_DEPTH samples (1..6)
EMA_SHIFT, 2, EMA weight shift; alpha = 2^-EMA_SHIFT (1..8)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
clear_in  input  1  synchronous flush of all filter state
mode_in  input  1  0 = boxcar, 1 = EMA
valid_in  input  1  one sample vector presented this cycle
value_in  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
value_out  output  CHANNELS*WIDTH  filtered values, same packing
valid_out  output  1  value_out updated this cycle (single-cycle pulse)
primed_out  output  1  window full (boxcar) or at least one sample taken (EMA)

Behaviour:
- Reset (rst_in low, asynchronous):
  - value_out=0, valid_out=0, primed_out=0.
  - All window entries, sums, EMA accumulators, write pointer and fill counter = 0.
  - Registered mode = 0.
- Latency: valid_in at cycle N gives valid_out=1 and new value_out at cycle N+1. valid_out is 0 otherwise. value_out holds its value between updates.
- There is no backpressure. A sample is accepted on every valid_in cycle, back-to-back included.
- Boxcar, per channel:
  - A circular buffer of 2^LOG2_DEPTH entries plus a running sum of WIDTH+LOG2_DEPTH bits.
  - On accept: sum_next = sum + new - buf[wptr]; buf[wptr] = new; wptr wraps mod depth.
  - value_out = sum_next >> LOG2_DEPTH (truncating).
  - The buffer starts at zero, so output ramps up during fill.
  - The fill counter saturates at depth. primed_out goes 1 on the cycle valid_out carries the depth-th sample.
- EMA, per channel:
  - Accumulator of WIDTH+EMA_SHIFT bits.
  - First accepted sample after reset or flush: acc = new << EMA_SHIFT.
  - Later samples: acc_next = acc + new - (acc >> EMA_SHIFT).
  - value_out = acc_next >> EMA_SHIFT.
  - primed_out = 1 from the first output onwards.
- Overflow: none is possible in either mode. The maximum input (2^WIDTH-1) repeated converges to the same output value.
- Flush: clear_in=1 zeroes buffers, sums, accumulators, wptr, fill counter and primed_out on the next edge. value_out holds its last value.
- Flush and sample in the same cycle: clear_in wins. The sample is discarded and valid_out stays 0 next cycle.
- Mode change: mode_in is registered every cycle. If it differs from the registered mode, that cycle acts as a flush. A coincident valid_in sample is discarded.
- Channels are fully independent. All channels share valid_in, wptr and the fill counter.

Test Plan:
- Boxcar, LOG2_DEPTH=2, ch0 samples 45, 55, 65, 55, 65, spaced 4 cycles apart -> value_out ch0 = 11, 25, 41, 55, 60. primed_out rises with the 4th output (55). valid_out is high exactly 1 cycle after each valid_in.
- EMA, EMA_SHIFT=1, ch0 samples 45, 55, 65 -> outputs 45, 50, 57. primed_out=1 after the first output.
- Back-to-back valid_in, boxcar, ch0 = 2047 for 6 cycles, ch1 = 0 -> ch0 ramps 511, 1023, 1535, 2047, 2047, 2047. ch1 stays 0 throughout, showing no overflow and no crosstalk.
- clear_in together with valid_in after 3 boxcar samples -> no valid_out and primed_out=0. The next sample 100 gives output 25.
- Toggle mode_in mid-stream from boxcar to EMA, then feed 40 -> implicit flush, and the first EMA output is 40.
- Assert rst_in low asynchronously mid-window, between clock edges -> all outputs 0 immediately. After release, the boxcar restarts from an empty window.

Source files
------------

// File: rtl/moving_avg_multi.sv
// Multi-channel moving-average filter: run-time selectable power-of-two boxcar or
// EMA (alpha = 2^-EMA_SHIFT), with flush, primed flag and registered outputs.

module moving_avg_lane #(
  parameter int WIDTH      = 11,
  parameter int LOG2_DEPTH = 2,
  parameter int EMA_SHIFT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  accept,
  input  logic                  mode,
  input  logic                  first,
  input  logic [LOG2_DEPTH-1:0] wptr,
  input  logic [WIDTH-1:0]      sample,
  output logic [WIDTH-1:0]      value
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam int AW    = WIDTH + EMA_SHIFT;

  logic [DEPTH-1:0][WIDTH-1:0] win;
  logic [SW-1:0]               sum, sum_nxt;
  logic [AW-1:0]               acc, acc_nxt;

  // The sum always contains win[wptr], so subtracting it cannot underflow.
  assign sum_nxt = sum + SW'(sample) - SW'(win[wptr]);
  // Decay before adding keeps the intermediate inside AW bits at full scale.
  assign acc_nxt = first ? (AW'(sample) << EMA_SHIFT)
                         : (acc - (acc >> EMA_SHIFT)) + AW'(sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win   <= '0;
      sum   <= '0;
      acc   <= '0;
      value <= '0;
    end else if (flush) begin
      win <= '0;
      sum <= '0;
      acc <= '0;
    end else if (accept) begin
      if (mode) begin
        acc   <= acc_nxt;
        value <= acc_nxt[AW-1:EMA_SHIFT];
      end else begin
        win[wptr] <= sample;
        sum       <= sum_nxt;
        value     <= sum_nxt[SW-1:LOG2_DEPTH];
      end
    end
  end
endmodule

module moving_avg_multi #(
  parameter int WIDTH      = 11,
  parameter int CHANNELS   = 2,
  parameter int LOG2_DEPTH = 2,
  parameter int EMA_SHIFT  = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      clear_in,
  input  logic                      mode_in,
  input  logic                      valid_in,
  input  logic [CHANNELS*WIDTH-1:0] value_in,
  output logic [CHANNELS*WIDTH-1:0] value_out,
  output logic                      valid_out,
  output logic                      primed_out
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic                  mode_q;
  logic                  flush, accept, first;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH:0]   fill, fill_nxt;

  // A mode change behaves exactly like clear_in for that cycle.
  assign flush    = clear_in | (mode_in ^ mode_q);
  assign accept   = valid_in & ~flush;
  assign first    = (fill == '0);
  assign fill_nxt = (fill == (LOG2_DEPTH+1)'(DEPTH)) ? fill : fill + 1'b1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q     <= 1'b0;
      wptr       <= '0;
      fill       <= '0;
      valid_out  <= 1'b0;
      primed_out <= 1'b0;
    end else begin
      mode_q    <= mode_in;
      valid_out <= accept;
      if (flush) begin
        wptr       <= '0;
        fill       <= '0;
        primed_out <= 1'b0;
      end else if (accept) begin
        wptr       <= wptr + 1'b1;
        fill       <= fill_nxt;
        primed_out <= mode_q | (fill_nxt == (LOG2_DEPTH+1)'(DEPTH));
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    moving_avg_lane #(
      .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .EMA_SHIFT(EMA_SHIFT)
    ) u_lane (
      .clk   (clk_in),
      .rst_n (rst_in),
      .flush (flush),
      .accept(accept),
      .mode  (mode_q),
      .first (first),
      .wptr  (wptr),
      .sample(value_in[k*WIDTH +: WIDTH]),
      .value (value_out[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_moving_avg_multi.sv
// Directed plus random check of moving_avg_multi against a queue-based reference.

module tb_moving_avg_multi;
  localparam int W     = 11;
  localparam int CH    = 2;
  localparam int LD    = 2;
  localparam int ES    = 1;
  localparam int DEPTH = 1 << LD;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              clear_in = 1'b0;
  logic              mode_in = 1'b0;
  logic              valid_in = 1'b0;
  logic [CH*W-1:0]   value_in = '0;
  logic [CH*W-1:0]   value_out;
  logic              valid_out;
  logic              primed_out;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  int m_win[CH][$];
  int m_acc[CH];
  int m_val[CH];
  int m_mode, m_valid, m_primed, m_started;

  moving_avg_multi #(.WIDTH(W), .CHANNELS(CH), .LOG2_DEPTH(LD), .EMA_SHIFT(ES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .mode_in(mode_in),
    .valid_in(valid_in), .value_in(value_in), .value_out(value_out),
    .valid_out(valid_out), .primed_out(primed_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_win[k].delete();
      m_acc[k] = 0;
      m_val[k] = 0;
    end
    m_mode = 0; m_valid = 0; m_primed = 0; m_started = 0;
  endtask

  task automatic model_flush();
    for (int k = 0; k < CH; k++) begin
      m_win[k].delete();
      m_acc[k] = 0;
    end
    m_primed = 0; m_started = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " valid"}, int'(valid_out), m_valid);
    chk({tag, " primed"}, int'(primed_out), m_primed);
    for (int k = 0; k < CH; k++)
      chk($sformatf("%s ch%0d", tag, k), int'(value_out[k*W +: W]), m_val[k]);
  endtask

  // Drive one cycle, advance the reference, check just after the edge.
  task automatic step(input string tag, input bit clr, input bit md, input bit vld,
                      input int v0, input int v1);
    int v[CH];
    int s;
    v[0] = v0; v[1] = v1;
    clear_in = clr; mode_in = md; valid_in = vld;
    value_in = {W'(v1), W'(v0)};
    @(posedge clk_in);
    if (clr || (int'(md) != m_mode)) begin
      model_flush();
      m_valid = 0;
    end else if (vld) begin
      m_valid = 1;
      for (int k = 0; k < CH; k++) begin
        if (m_mode == 0) begin
          m_win[k].push_back(v[k]);
          if (m_win[k].size() > DEPTH) void'(m_win[k].pop_front());
          s = 0;
          foreach (m_win[k][i]) s += m_win[k][i];
          m_val[k] = s / DEPTH;
        end else begin
          if (!m_started) m_acc[k] = v[k] * (1 << ES);
          else m_acc[k] = m_acc[k] + v[k] - m_acc[k] / (1 << ES);
          m_val[k] = m_acc[k] / (1 << ES);
        end
      end
      if (m_mode == 0) m_primed = (m_win[0].size() == DEPTH);
      else m_primed = 1;
      m_started = 1;
    end else begin
      m_valid = 0;
    end
    m_mode = md;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) step("idle", 1'b0, md, 1'b0, 0, 0);
  endtask

  initial begin
    int bx[5];
    int mode_r;
    bx = '{45, 55, 65, 55, 65};
    model_reset();
    #2;
    check_all("reset");
    #10 rst_in = 1'b1;

    // boxcar ramp, spaced samples; known outputs 11,25,41,55,60
    for (int i = 0; i < 5; i++) begin
      step("box", 1'b0, 1'b0, 1'b1, bx[i], 0);
      idle(3, 1'b0);
    end
    chk("box last", int'(value_out[W-1:0]), 60);

    // switch to EMA: the switching cycle discards its sample
    step("modechg", 1'b0, 1'b1, 1'b1, 999, 5);
    step("ema", 1'b0, 1'b1, 1'b1, 45, 0);
    step("ema", 1'b0, 1'b1, 1'b1, 55, 0);
    step("ema", 1'b0, 1'b1, 1'b1, 65, 0);
    chk("ema last", int'(value_out[W-1:0]), 57);

    // back to boxcar, full-scale back-to-back on ch0, ch1 zero
    step("modechg2", 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) step("max", 1'b0, 1'b0, 1'b1, 2047, 0);
    chk("max ch0", int'(value_out[W-1:0]), 2047);

    // clear with coincident sample, then 100 -> 25
    step("clr0", 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step("pre", 1'b0, 1'b0, 1'b1, 10 + i, 20);
    step("clrvld", 1'b1, 1'b0, 1'b1, 500, 500);
    step("post", 1'b0, 1'b0, 1'b1, 100, 0);
    chk("post ch0", int'(value_out[W-1:0]), 25);

    // boxcar to EMA mid-stream, first EMA output equals input
    step("b", 1'b0, 1'b0, 1'b1, 300, 7);
    step("tog", 1'b0, 1'b1, 1'b0, 0, 0);
    step("ema40", 1'b0, 1'b1, 1'b1, 40, 41);
    chk("ema40 ch0", int'(value_out[W-1:0]), 40);

    // asynchronous reset between edges mid-window
    step("b", 1'b0, 1'b1, 1'b0, 0, 0);
    step("b", 1'b0, 1'b0, 1'b0, 0, 0);
    step("b", 1'b0, 1'b0, 1'b1, 800, 900);
    step("b", 1'b0, 1'b0, 1'b1, 800, 900);
    #2 rst_in = 1'b0;
    valid_in = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    step("restart", 1'b0, 1'b0, 1'b1, 400, 8);
    chk("restart ch0", int'(value_out[W-1:0]), 100);

    // random traffic
    mode_r = 0;
    for (int i = 0; i < 400; i++) begin
      bit clr, vld;
      int a, b;
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) mode_r = 1 - mode_r;
      vld = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 3) == 0) ? 2047 : int'($urandom_range(0, 2047));
      b = int'($urandom_range(0, 2047));
      step("rnd", clr, mode_r[0], vld, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
